// File: rtl/mux_scan_seq.sv
// Serializes a 16-bit word by stepping the select of a downstream 16:1 mux and passing its F output to out_bit.
// Optional macro MUX_SCAN_PARITY_EN appends an even-parity bit (state PAR) that carries out_last.

module mux_scan_seq #(
    parameter int unsigned SCAN_DIR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] mux_a,
    output logic [3:0]  mux_s,
    input  logic        mux_f,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_bit,
    output logic        out_last,
    output logic        busy
);
    localparam logic [3:0] S_START = (SCAN_DIR == 0) ? 4'd0 : 4'd15;
    localparam logic [3:0] S_END   = (SCAN_DIR == 0) ? 4'd15 : 4'd0;
    // Descending scan adds 15, i.e. -1 modulo 16.
    localparam logic [3:0] S_STEP  = (SCAN_DIR == 0) ? 4'd1 : 4'd15;

`ifdef MUX_SCAN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SCAN, PAR} state_t;
    logic par_bit;
`else
    typedef enum logic [0:0] {IDLE, SCAN} state_t;
`endif

    state_t     state;
    logic       xfer;
    logic [3:0] s_next;

    assign xfer   = out_valid & out_ready;
    assign s_next = mux_s + S_STEP;

    // Zero-latency data path: the mux result goes straight out while scanning.
`ifdef MUX_SCAN_PARITY_EN
    always_comb begin
        out_bit = 1'b0;
        if (state == SCAN) begin
            out_bit = mux_f;
        end else if (state == PAR) begin
            out_bit = par_bit;
        end
    end
`else
    assign out_bit = (state == SCAN) & mux_f;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mux_a     <= 16'h0000;
            mux_s     <= S_START;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_last  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mux_a     <= in_data;
                        mux_s     <= S_START;
                        state     <= SCAN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                        par_bit   <= ^in_data;
`endif
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        if (mux_s != S_END) begin
                            mux_s <= s_next;
`ifndef MUX_SCAN_PARITY_EN
                            out_last <= (s_next == S_END);
`endif
                        end else begin
                            mux_s <= S_START;
`ifdef MUX_SCAN_PARITY_EN
                            state    <= PAR;
                            out_last <= 1'b1;
`else
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef MUX_SCAN_PARITY_EN
                PAR: begin
                    if (xfer) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: ascending and descending instances side by side, checked every cycle
// against a bit-position model, plus literal expectations for the scan sequences.

module tb_mux_scan_seq;

`ifdef MUX_SCAN_PARITY_EN
    localparam int LEN = 17;
`else
    localparam int LEN = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic [1:0]  in_ready_w, out_valid_w, out_bit_w, out_last_w, busy_w, mux_f_w;
    logic [15:0] mux_a_w [2];
    logic [3:0]  mux_s_w [2];
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mux_scan_seq #(.SCAN_DIR(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .mux_a(mux_a_w[0]), .mux_s(mux_s_w[0]), .mux_f(mux_f_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_bit(out_bit_w[0]),
        .out_last(out_last_w[0]), .busy(busy_w[0])
    );

    mux_scan_seq #(.SCAN_DIR(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .mux_a(mux_a_w[1]), .mux_s(mux_s_w[1]), .mux_f(mux_f_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_bit(out_bit_w[1]),
        .out_last(out_last_w[1]), .busy(busy_w[1])
    );

    // Downstream 16:1 muxes.
    assign mux_f_w[0] = mux_a_w[0][mux_s_w[0]];
    assign mux_f_w[1] = mux_a_w[1][mux_s_w[1]];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word in flight is just "how many bits have been handed over so far".
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic [15:0] m_a    [2] = '{16'h0, 16'h0};
    int          m_pos  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] <= 1'b0;
                m_a[d]    <= 16'h0000;
                m_pos[d]  <= 0;
            end else if (!m_busy[d]) begin
                if (in_valid) begin
                    m_a[d]    <= in_data;
                    m_busy[d] <= 1'b1;
                    m_pos[d]  <= 0;
                end
            end else if (out_ready) begin
                if (m_pos[d] == LEN - 1) begin
                    m_busy[d] <= 1'b0;
                    m_pos[d]  <= 0;
                end else begin
                    m_pos[d] <= m_pos[d] + 1;
                end
            end
        end
    end

    function automatic logic [3:0] exp_s(input int d);
        if (!m_busy[d] || m_pos[d] > 15) return (d == 1) ? 4'd15 : 4'd0;
        return 4'((d == 1) ? 15 - m_pos[d] : m_pos[d]);
    endfunction

    function automatic logic exp_bit(input int d);
        if (m_pos[d] > 15) return ^m_a[d];
        return m_a[d][exp_s(d)];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("u%0d in_ready", d), 16'(in_ready_w[d]), 16'(!m_busy[d]));
                chk($sformatf("u%0d out_valid", d), 16'(out_valid_w[d]), 16'(m_busy[d]));
                chk($sformatf("u%0d busy", d), 16'(busy_w[d]), 16'(m_busy[d]));
                chk($sformatf("u%0d mux_a", d), mux_a_w[d], m_a[d]);
                chk($sformatf("u%0d mux_s", d), 16'(mux_s_w[d]), 16'(exp_s(d)));
                chk($sformatf("u%0d out_last", d), 16'(out_last_w[d]),
                    16'(m_busy[d] && m_pos[d] == LEN - 1));
                if (m_busy[d]) chk($sformatf("u%0d out_bit", d), 16'(out_bit_w[d]), 16'(exp_bit(d)));
            end
        end
    end

    task automatic load(input logic [15:0] w);
        int n = 0;
        while (in_ready_w != 2'b11 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("load_wait", 16'(in_ready_w), 16'h0003);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'h5a5a;
    endtask

    // Walks one word; records bits in emission order (b[k] = k-th bit sent).
    task automatic collect(input int stall_at, input int rst_at, input logic junk,
                           output logic [15:0] b0, output logic [15:0] b1, output logic par0,
                           output int last0, output logic [3:0] s1_last);
        b0 = 16'h0; b1 = 16'h0; par0 = 1'b0; last0 = -1; s1_last = 4'h0;
        for (int step = 0; step < LEN; step++) begin
            if (step == rst_at) begin
                rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
                @(posedge clk); #1;
                rst = 1'b0; in_valid = 1'b0;
                return;
            end
            if (step == stall_at) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk("stall_mux_s", 16'(mux_s_w[0]), 16'd4);
                    chk("stall_out_bit", 16'(out_bit_w[0]), 16'd1);
                end
                out_ready = 1'b1;
            end
            if (step < 16) begin
                b0[step] = out_bit_w[0];
                b1[step] = out_bit_w[1];
            end else begin
                par0 = out_bit_w[0];
            end
            if (out_last_w[0] && last0 < 0) last0 = step;
            if (step == 15) s1_last = mux_s_w[1];
            in_valid = junk && (step < LEN - 1);
            in_data  = 16'hdead;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] b0, b1;
        logic        p0;
        int          l0;
        logic [3:0]  s1;

        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_in_ready", 16'(in_ready_w), 16'h0003);
        chk("rst_out_valid", 16'(out_valid_w), 16'h0000);
        chk("rst_busy", 16'(busy_w), 16'h0000);
        chk("rst_out_last", 16'(out_last_w), 16'h0000);
        chk("rst_mux_a", mux_a_w[0], 16'h0000);
        chk("rst_mux_s_up", 16'(mux_s_w[0]), 16'd0);
        chk("rst_mux_s_down", 16'(mux_s_w[1]), 16'd15);

        load(16'h3f0a);
        collect(-1, -1, 1'b0, b0, b1, p0, l0, s1);
        chk("seq_3f0a_up", b0, 16'h3f0a);
        chk("seq_3f0a_down", b1, 16'h50fc);
        chk("last_3f0a", 16'(l0), 16'(LEN - 1));
`ifdef MUX_SCAN_PARITY_EN
        chk("parity_3f0a", 16'(p0), 16'd0);
`endif
        chk("idle_after_3f0a", 16'(busy_w), 16'h0000);

        load(16'h8001);
        collect(-1, -1, 1'b0, b0, b1, p0, l0, s1);
        chk("seq_8001_down", b1, 16'h8001);
        chk("seq_8001_up", b0, 16'h8001);
        chk("down_last_sel", 16'(s1), 16'd0);

        load(16'h00ff);
        collect(4, -1, 1'b1, b0, b1, p0, l0, s1);
        chk("seq_00ff_stall", b0, 16'h00ff);
        chk("hold_mux_a_00ff", mux_a_w[0], 16'h00ff);
        chk("last_00ff", 16'(l0), 16'(LEN - 1));

        load(16'hffff);
        collect(-1, 7, 1'b0, b0, b1, p0, l0, s1);
        chk("midrst_out_valid", 16'(out_valid_w), 16'h0000);
        chk("midrst_busy", 16'(busy_w), 16'h0000);
        chk("midrst_mux_a", mux_a_w[0], 16'h0000);
        chk("midrst_mux_s", 16'(mux_s_w[0]), 16'd0);

        load(16'h0001);
        collect(-1, -1, 1'b0, b0, b1, p0, l0, s1);
        chk("seq_0001_up", b0, 16'h0001);
        chk("seq_0001_down", b1, 16'h8000);
`ifdef MUX_SCAN_PARITY_EN
        chk("parity_0001", 16'(p0), 16'd1);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
